axi_lite_ram_bridge: RTL

//  AXI4-Lite slave that owns one access port of the MMU's 1024x32 block RAM, turning bus reads/writes into RAM_* cycles.

---
 rtl/axi_lite_ram_bridge.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_ram_bridge.sv
// AXI4-Lite slave that owns one access port of a 1024x32 block RAM.
// One transaction at a time; partial-strobe writes are done as read-modify-write.
module axi_lite_ram_bridge #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] S_AWADDR,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [31:0]           S_WDATA,
    input  logic [3:0]            S_WSTRB,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_ARADDR,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    output logic [31:0]           S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RVALID,
    input  logic                  S_RREADY,
    output logic                  RAM_RDEN,
    output logic [9:0]            RAM_RADDR,
    input  logic [31:0]           RAM_RDATA,
    output logic                  RAM_WREN,
    output logic [9:0]            RAM_WADDR,
    output logic [31:0]           RAM_WDATA
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned WORD_AW = 10;
    localparam int unsigned WIN_LSB = 12;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE, RD_ISS, RD_CAP, RD_RSP, WR_RD, WR_CAP, WR_WR, WR_RSP
    } state_t;

    state_t state, state_d;
    logic   favour_read, favour_read_d;

    logic               aw_held, aw_in_win;
    logic [WORD_AW-1:0] aw_word;
    logic               w_held;
    logic [DATA_W-1:0]  w_data;
    logic [STRB_W-1:0]  w_strb;

    logic aw_hs, w_hs, b_hs, wr_pend;
    logic ar_in_win, aw_addr_in_win;
    logic addr_lsb_unused;
    logic [DATA_W-1:0] merged;

    logic               arready_d, rvalid_d, bvalid_d, rden_d, wren_d;
    logic [DATA_W-1:0]  rdata_d, wdata_d;
    logic [1:0]         rresp_d, bresp_d;
    logic [WORD_AW-1:0] raddr_d, waddr_d;

    assign aw_hs   = S_AWVALID && S_AWREADY;
    assign w_hs    = S_WVALID && S_WREADY;
    assign b_hs    = S_BVALID && S_BREADY;
    assign wr_pend = aw_held && w_held;

    assign ar_in_win      = (S_ARADDR[ADDR_WIDTH-1:WIN_LSB] == BASE_ADDR[ADDR_WIDTH-1:WIN_LSB]);
    assign aw_addr_in_win = (S_AWADDR[ADDR_WIDTH-1:WIN_LSB] == BASE_ADDR[ADDR_WIDTH-1:WIN_LSB]);
    assign addr_lsb_unused = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

    // AW and W holding registers fill independently and drain on the B handshake
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            aw_held   <= 1'b0;
            aw_in_win <= 1'b0;
            aw_word   <= '0;
            w_held    <= 1'b0;
            w_data    <= '0;
            w_strb    <= '0;
            S_AWREADY <= 1'b0;
            S_WREADY  <= 1'b0;
        end else begin
            if (b_hs) begin
                aw_held <= 1'b0;
            end else if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_word   <= S_AWADDR[WIN_LSB-1:2];
                aw_in_win <= aw_addr_in_win;
            end
            if (b_hs) begin
                w_held <= 1'b0;
            end else if (w_hs) begin
                w_held <= 1'b1;
                w_data <= S_WDATA;
                w_strb <= S_WSTRB;
            end
            S_AWREADY <= b_hs || (!aw_held && !aw_hs);
            S_WREADY  <= b_hs || (!w_held && !w_hs);
        end
    end

    // Byte merge of new write data over the old word returned by the RAM
    always_comb begin
        merged = RAM_RDATA;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (w_strb[i]) merged[8*i +: 8] = w_data[8*i +: 8];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            favour_read <= 1'b1;
            S_ARREADY   <= 1'b0;
            S_RVALID    <= 1'b0;
            S_RDATA     <= '0;
            S_RRESP     <= RESP_OKAY;
            S_BVALID    <= 1'b0;
            S_BRESP     <= RESP_OKAY;
            RAM_RDEN    <= 1'b0;
            RAM_RADDR   <= '0;
            RAM_WREN    <= 1'b0;
            RAM_WADDR   <= '0;
            RAM_WDATA   <= '0;
        end else begin
            state       <= state_d;
            favour_read <= favour_read_d;
            S_ARREADY   <= arready_d;
            S_RVALID    <= rvalid_d;
            S_RDATA     <= rdata_d;
            S_RRESP     <= rresp_d;
            S_BVALID    <= bvalid_d;
            S_BRESP     <= bresp_d;
            RAM_RDEN    <= rden_d;
            RAM_RADDR   <= raddr_d;
            RAM_WREN    <= wren_d;
            RAM_WADDR   <= waddr_d;
            RAM_WDATA   <= wdata_d;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d       = state;
        favour_read_d = favour_read;
        arready_d     = 1'b0;
        rvalid_d      = S_RVALID;
        rdata_d       = S_RDATA;
        rresp_d       = S_RRESP;
        bvalid_d      = S_BVALID;
        bresp_d       = S_BRESP;
        rden_d        = 1'b0;
        raddr_d       = RAM_RADDR;
        wren_d        = 1'b0;
        waddr_d       = RAM_WADDR;
        wdata_d       = RAM_WDATA;

        case (state)
            IDLE: begin
                // A raised ARREADY commits this slot to the read
                if (S_ARREADY) begin
                    if (S_ARVALID) begin
                        if (ar_in_win) begin
                            state_d = RD_ISS;
                            rden_d  = 1'b1;
                            raddr_d = S_ARADDR[WIN_LSB-1:2];
                        end else begin
                            state_d  = RD_RSP;
                            rvalid_d = 1'b1;
                            rdata_d  = '0;
                            rresp_d  = RESP_DECERR;
                        end
                    end
                end else if (S_ARVALID && (!wr_pend || favour_read)) begin
                    arready_d = 1'b1;
                    if (wr_pend) favour_read_d = 1'b0;
                end else if (wr_pend) begin
                    if (S_ARVALID) favour_read_d = 1'b1;
                    if (!aw_in_win) begin
                        state_d  = WR_RSP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_DECERR;
                    end else if (w_strb == '0) begin
                        state_d  = WR_RSP;
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else if (&w_strb) begin
                        state_d = WR_WR;
                        wren_d  = 1'b1;
                        waddr_d = aw_word;
                        wdata_d = w_data;
                    end else begin
                        state_d = WR_RD;
                        rden_d  = 1'b1;
                        raddr_d = aw_word;
                    end
                end
            end
            RD_ISS: state_d = RD_CAP;
            RD_CAP: begin
                state_d  = RD_RSP;
                rvalid_d = 1'b1;
                rdata_d  = RAM_RDATA;
                rresp_d  = RESP_OKAY;
            end
            RD_RSP: begin
                if (S_RREADY) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            WR_RD:  state_d = WR_CAP;
            WR_CAP: begin
                state_d = WR_WR;
                wren_d  = 1'b1;
                waddr_d = aw_word;
                wdata_d = merged;
            end
            WR_WR: begin
                state_d  = WR_RSP;
                bvalid_d = 1'b1;
                bresp_d  = RESP_OKAY;
            end
            WR_RSP: begin
                if (S_BREADY) begin
                    state_d  = IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
